// File: rtl/time_mux_accumulator.sv
// Purpose: time-multiplexed FIR tap accumulator; walks a one-hot tap select over N taps,
//          sums the shared multiplier's products, then rounds down and saturates to WIO.WFO.
// Latency: start sampled at one edge -> N accumulate cycles -> y/y_valid in the following OUT cycle.
// Backpressure: none; start is ignored during RUN, and start in OUT chains runs back to back.
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   start               - request one new sample (honoured in IDLE or OUT)
//   prod [WII+WFI]      - signed product for the tap currently selected by oneHot
//   oneHot [N]          - tap select, one-hot during RUN, zero otherwise
//   busy                - high exactly while in RUN
//   y [WIO+WFO], sat    - saturated result and clip flag, registered on entry to OUT
//   y_valid             - one-cycle strobe during OUT
module time_mux_accumulator #(
  parameter int N   = 3,
  parameter int WII = 2,
  parameter int WFI = 6,
  parameter int WIO = 2,
  parameter int WFO = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WII+WFI-1:0]   prod,
  output logic [N-1:0]         oneHot,
  output logic                 busy,
  output logic [WIO+WFO-1:0]   y,
  output logic                 y_valid,
  output logic                 sat
);

  localparam int WP   = WII + WFI;
  localparam int WA   = WP + $clog2(N);            // N products of WP bits cannot overflow this
  localparam int WY   = WIO + WFO;
  localparam int SH_R = (WFI > WFO) ? (WFI - WFO) : 0;
  localparam int SH_L = (WFO > WFI) ? (WFO - WFI) : 0;
  localparam int WX   = WA + SH_L;
  localparam int WC   = ((WX > WY) ? WX : WY) + 1; // room to compare against both clip limits

  localparam logic signed [WC-1:0] SAT_MAX = {{(WC-WY+1){1'b0}}, {(WY-1){1'b1}}};
  localparam logic signed [WC-1:0] SAT_MIN = {{(WC-WY+1){1'b1}}, {(WY-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t               state;
  logic signed [WA-1:0] acc;
  logic signed [WA-1:0] acc_next;
  logic signed [WC-1:0] scaled;
  logic                 clip_hi;
  logic                 clip_lo;
  logic [WY-1:0]        y_next;

  // The final tap's product is folded in combinationally so y can be
  // captured on the same edge that finishes the accumulation.
  always_comb begin
    acc_next = acc + $signed({{(WA-WP){prod[WP-1]}}, prod});
    scaled   = $signed({{(WC-WA){acc_next[WA-1]}}, acc_next});
    // Arithmetic right shift floors; left shift zero-pads the fraction.
    scaled   = (scaled >>> SH_R) <<< SH_L;
    clip_hi  = (scaled > SAT_MAX);
    clip_lo  = (scaled < SAT_MIN);
    if (clip_hi)
      y_next = SAT_MAX[WY-1:0];
    else if (clip_lo)
      y_next = SAT_MIN[WY-1:0];
    else
      y_next = scaled[WY-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      oneHot  <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
      sat     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          acc <= acc_next;
          if (oneHot[N-1]) begin
            state   <= OUT;
            oneHot  <= '0;
            busy    <= 1'b0;
            y       <= y_next;
            sat     <= clip_hi | clip_lo;
            y_valid <= 1'b1;
          end else begin
            oneHot  <= {oneHot[N-2:0], oneHot[N-1]};
          end
        end
        default: begin  // IDLE and OUT behave identically on start
          y_valid <= 1'b0;
          sat     <= 1'b0;
          if (start) begin
            state  <= RUN;
            acc    <= '0;
            oneHot <= N'(1);
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            oneHot <= '0;
            busy   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_mux_accumulator.sv
// Purpose: directed + randomized checks of time_mux_accumulator against a sum/floor/clamp model.
// Latency: y_valid expected in the cycle after the N-th accumulate edge following the start edge.
// Backpressure: n/a (bench drives start/prod directly).
module tb_time_mux_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] prod = '0;
  logic [2:0] oneHot;
  logic       busy, y_valid, sat;
  logic [7:0] y;

  // Second instance: N=4, 8 fractional input bits, 6 fractional output bits.
  logic       start2 = 1'b0;
  logic [9:0] prod2 = '0;
  logic [3:0] oneHot2;
  logic       busy2, y_valid2, sat2;
  logic [7:0] y2;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] last_y = '0;

  always #5 clk = ~clk;

  time_mux_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prod(prod),
    .oneHot(oneHot), .busy(busy), .y(y), .y_valid(y_valid), .sat(sat)
  );

  time_mux_accumulator #(.N(4), .WII(2), .WFI(8), .WIO(2), .WFO(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .prod(prod2),
    .oneHot(oneHot2), .busy(busy2), .y(y2), .y_valid(y_valid2), .sat(sat2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer sum in input LSBs -> rescale (floor) -> clamp to WY-bit signed.
  function automatic int conv(input int sum, input int wfi, input int wfo, input int wy,
                              output bit s);
    int v, d, hi, lo;
    if (wfo < wfi) begin
      d = 1 << (wfi - wfo);
      v = (sum - (((sum % d) + d) % d)) / d;
    end else begin
      v = sum * (1 << (wfo - wfi));
    end
    hi = (1 << (wy - 1)) - 1;
    lo = -(1 << (wy - 1));
    s  = (v > hi) || (v < lo);
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v;
  endfunction

  // Issues start at the next edge, feeds three taps, checks the OUT cycle.
  // Returns at the falling edge inside the OUT cycle.
  task automatic do_run(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                        input bit hold);
    logic [7:0] taps [3];
    logic [7:0] ey;
    int sum, v;
    bit s;
    taps[0] = p0; taps[1] = p1; taps[2] = p2;
    start = 1'b1;
    prod  = 8'($urandom);
    @(posedge clk);
    sum = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("onehot_run", {29'd0, oneHot}, 32'(1 << k));
      prod  = taps[k];
      start = hold;
      sum   = sum + $signed(taps[k]);
      @(posedge clk);
    end
    @(negedge clk);
    v  = conv(sum, 6, 6, 8, s);
    ey = v[7:0];
    chk("y_valid_out", {31'd0, y_valid}, 32'd1);
    chk("y_out", {24'd0, y}, {24'd0, ey});
    chk("sat_out", {31'd0, sat}, {31'd0, s});
    chk("busy_out", {31'd0, busy}, 32'd0);
    chk("onehot_out", {29'd0, oneHot}, 32'd0);
    last_y = ey;
  endtask

  task automatic idle_check();
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("y_valid_idle", {31'd0, y_valid}, 32'd0);
    chk("y_hold", {24'd0, y}, {24'd0, last_y});
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("onehot_idle", {29'd0, oneHot}, 32'd0);
  endtask

  task automatic do_run2(input bit rnd);
    logic [9:0] tap;
    logic [7:0] ey;
    int sum, v;
    bit s;
    start2 = 1'b1;
    @(posedge clk);
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("onehot2_run", {28'd0, oneHot2}, 32'(1 << k));
      tap    = rnd ? 10'($urandom) : 10'h3FF;
      prod2  = tap;
      start2 = 1'b0;
      sum    = sum + $signed(tap);
      @(posedge clk);
    end
    @(negedge clk);
    v  = conv(sum, 8, 6, 8, s);
    ey = v[7:0];
    chk("y_valid2_out", {31'd0, y_valid2}, 32'd1);
    chk("y2_out", {24'd0, y2}, {24'd0, ey});
    chk("sat2_out", {31'd0, sat2}, {31'd0, s});
  endtask

  initial begin
    // Reset held across a few edges, then check every output is cleared.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_onehot", {29'd0, oneHot}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_y", {24'd0, y}, 32'd0);
    chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_valid", {31'd0, y_valid}, 32'd0);
    end

    // Directed: mixed signs, positive clip, negative clip.
    do_run(8'h10, 8'h20, 8'hF0, 1'b0);
    chk("dir_y_0x20", {24'd0, y}, 32'h20);
    idle_check();
    do_run(8'h40, 8'h40, 8'h40, 1'b0);
    chk("dir_sat_hi", {23'd0, sat, y}, 32'h17F);
    idle_check();
    do_run(8'h80, 8'h80, 8'h80, 1'b0);
    chk("dir_sat_lo", {23'd0, sat, y}, 32'h180);
    idle_check();

    // Reset in the middle of RUN while oneHot=010.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("abort_onehot1", {29'd0, oneHot}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("abort_onehot2", {29'd0, oneHot}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_onehot", {29'd0, oneHot}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_y", {24'd0, y}, 32'd0);
    chk("abort_y_valid", {31'd0, y_valid}, 32'd0);
    chk("abort_sat", {31'd0, sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_y = '0;
    repeat (6) begin
      @(negedge clk);
      chk("post_abort_valid", {31'd0, y_valid}, 32'd0);
      chk("post_abort_y", {24'd0, y}, 32'd0);
    end

    // Randomized single runs.
    repeat (8) begin
      do_run(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      idle_check();
    end

    // start held high: runs chain from OUT with no IDLE gap, start in RUN ignored.
    repeat (4) do_run(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    idle_check();

    // Wider-fraction instance: -1 input LSB per tap floors to -1 output LSB.
    do_run2(1'b0);
    chk("dut2_minus_lsb", {23'd0, sat2, y2}, 32'h0FF);
    repeat (4) do_run2(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
